// File: rtl/mac_pkg.sv
// Shared constants for the gated MAC column: instruction bit positions and default sizes.
package mac_pkg;

    localparam int unsigned INST_LOAD = 0;
    localparam int unsigned INST_EXEC = 1;

    localparam int unsigned DEF_BW = 8;
    localparam int unsigned DEF_PR = 8;

endpackage

// File: rtl/mac_lane_gated.sv
// One MAC lane: operand-hold registers, gated signed multiplier and product register.
module mac_lane_gated #(
    parameter int unsigned bw = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic                  gate,
    input  logic                  valid_s1,
    input  logic [bw-1:0]         q,
    input  logic [bw-1:0]         k,
    output logic signed [2*bw-1:0] prod
);

    logic signed [bw-1:0]   q_op;
    logic signed [bw-1:0]   k_op;
    logic                   gate_q;
    logic signed [2*bw-1:0] mult;

    assign mult = q_op * k_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_op   <= '0;
            k_op   <= '0;
            gate_q <= 1'b0;
            prod   <= '0;
        end else begin
            if (issue) begin
                gate_q <= gate;
                // Gated lanes keep their old operands so the multiplier inputs stay quiet.
                if (!gate) begin
                    q_op <= q;
                    k_op <= k;
                end
            end
            if (valid_s1) begin
                prod <= gate_q ? '0 : mult;
            end
        end
    end

endmodule

// File: rtl/mac_col_pipe_gated.sv
// Systolic MAC column: K slot storage, pr gated lanes and a 3-stage dot-product pipeline.
module mac_col_pipe_gated
    import mac_pkg::*;
#(
    parameter int unsigned bw      = DEF_BW,
    parameter int unsigned pr      = DEF_PR,
    parameter int unsigned bw_psum = 2 * bw + 4,
    parameter int unsigned kdepth  = 4,
    parameter int          col_id  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [pr*bw-1:0]           q_in,
    input  logic [pr-1:0]              q_zero,
    input  logic [1:0]                 i_inst,
    input  logic [$clog2(kdepth)-1:0]  i_kaddr,
    output logic [pr*bw-1:0]           q_out,
    output logic [1:0]                 o_inst,
    output logic [bw_psum-1:0]         out,
    output logic                       fifo_wr,
    output logic [15:0]                gated_cnt
);

    logic unused_col;
    assign unused_col = ^col_id;

    logic [pr*bw-1:0] k_mem  [kdepth];
    logic [pr-1:0]    kz_mem [kdepth];

    logic                      load;
    logic                      exec;
    logic [pr-1:0]             gate;
    logic [pr*bw-1:0]          k_sel;
    logic                      v1;
    logic                      v2;
    logic signed [2*bw-1:0]    prods [pr];
    logic signed [bw_psum-1:0] sum;
    logic [16:0]               cnt_add;
    logic [15:0]               cnt_next;

    // A simultaneous load+execute is treated as load only.
    assign load  = i_inst[INST_LOAD];
    assign exec  = i_inst[INST_EXEC] & ~i_inst[INST_LOAD];
    assign gate  = q_zero | kz_mem[i_kaddr];
    assign k_sel = k_mem[i_kaddr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(kdepth); s++) begin
                k_mem[s]  <= '0;
                kz_mem[s] <= '1;
            end
        end else if (load) begin
            k_mem[i_kaddr]  <= q_in;
            kz_mem[i_kaddr] <= q_zero;
        end
    end

    for (genvar i = 0; i < int'(pr); i++) begin : g_lane
        mac_lane_gated #(
            .bw (bw)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .issue    (exec),
            .gate     (gate[i]),
            .valid_s1 (v1),
            .q        (q_in[i*bw +: bw]),
            .k        (k_sel[i*bw +: bw]),
            .prod     (prods[i])
        );
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(pr); i++) begin
            sum = sum + bw_psum'(prods[i]);
        end
    end

    always_comb begin
        cnt_add = {1'b0, gated_cnt};
        for (int i = 0; i < int'(pr); i++) begin
            cnt_add = cnt_add + 17'(gate[i]);
        end
        cnt_next = cnt_add[16] ? 16'hFFFF : cnt_add[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            fifo_wr   <= 1'b0;
            out       <= '0;
            q_out     <= '0;
            o_inst    <= '0;
            gated_cnt <= '0;
        end else begin
            v1      <= exec;
            v2      <= v1;
            fifo_wr <= v2;
            if (v2) begin
                out <= sum;
            end
            q_out  <= q_in;
            o_inst <= i_inst;
            if (exec) begin
                gated_cnt <= cnt_next;
            end
        end
    end

endmodule
